// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit scheduling slice.
// Contents:
//   UART_D_WIDTH  - data width of the UART transmit core
//   sched_state_t - scheduler FSM states
//   id_width()    - width of an index into a set of n requesters (minimum 1)
package uart_ctrl_pkg;

    localparam int UART_D_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } sched_state_t;

    // A single requester still needs a 1-bit id so port widths never collapse to zero.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an optional lock.
// Ports:
//   req     in   N   request vector
//   ptr     in   IW  highest-priority index when not locked
//   lock_en in   1   restrict the grant to lock_id only
//   lock_id in   IW  index that owns the lock
//   grant   out  N   one-hot grant (all zero when nobody eligible requests)
//   id      out  IW  encoded index of the grant
//   found   out  1   grant is non-zero
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          lock_en,
    input  logic [IW-1:0] lock_id,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] id,
    output logic          found
);

    // Search upward from ptr with wrap-around; a lock bypasses the search entirely.
    always_comb begin : search
        logic [IW-1:0] idx;
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = '0;
        if (lock_en) begin
            if (req[lock_id]) begin
                grant[lock_id] = 1'b1;
                id             = lock_id;
                found          = 1'b1;
            end
        end else begin
            for (int off = 0; off < N; off++) begin
                idx = IW'((int'(ptr) + off) % N);
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    id         = idx;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
// Multi-byte messages keep the grant until a byte flagged last is accepted.
// Ports:
//   clk, rst         clock (posedge) and asynchronous active-low reset
//   req_valid/data/last  per-requester byte offer; byte i at [i*D_WIDTH +: D_WIDTH]
//   req_ready        one-hot combinational accept, only in IDLE with the transmitter free
//   tx_ena, tx_data  registered launch pulse and byte to the transmitter
//   tx_busy          transmitter busy
//   grant_id         current or last granted requester
//   locked           message in progress, grant held
//   err_start        sticky: transmitter failed to raise busy within START_TO cycles
module uart_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int D_WIDTH  = UART_D_WIDTH,
    parameter  int START_TO = 4,
    localparam int IW       = id_width(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*D_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_ena,
    output logic [D_WIDTH-1:0]       tx_data,
    input  logic                     tx_busy,
    output logic [IW-1:0]            grant_id,
    output logic                     locked,
    output logic                     err_start
);

    localparam int CW = $clog2(START_TO + 1);

    sched_state_t  state, state_next;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0] arb_id;
    logic          arb_found;
    logic          accept;
    logic          timeout;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] id);
        return IW'((int'(id) + 1) % N_REQ);
    endfunction

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .lock_en (locked),
        .lock_id (grant_id),
        .grant   (arb_grant),
        .id      (arb_id),
        .found   (arb_found)
    );

    // A frame left running by a reset keeps tx_busy high; that alone blocks new accepts.
    assign accept    = (state == IDLE) && rst && !tx_busy && arb_found;
    assign req_ready = accept ? arb_grant : '0;
    assign timeout   = (state == WAIT_BUSY) && !tx_busy && (cnt == CW'(START_TO - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = LAUNCH;
            LAUNCH:    state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)      state_next = WAIT_DONE;
                else if (timeout) state_next = IDLE;
            end
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // The pointer moves only at message boundaries (last byte or an aborted launch),
    // so bytes inside a locked message never rotate priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ena    <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            locked    <= 1'b0;
            err_start <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            tx_ena <= accept;
            if (accept) begin
                tx_data  <= req_data[int'(arb_id) * D_WIDTH +: D_WIDTH];
                grant_id <= arb_id;
                locked   <= ~req_last[arb_id];
                if (req_last[arb_id]) ptr <= next_ptr(arb_id);
            end
            if (state == LAUNCH) begin
                cnt <= '0;
            end else if ((state == WAIT_BUSY) && !tx_busy) begin
                cnt <= cnt + CW'(1);
            end
            if (timeout) begin
                err_start <= 1'b1;
                locked    <= 1'b0;
                ptr       <= next_ptr(grant_id);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: per-requester byte queues, a transmitter
// responder, and a cycle-level behavioural model of the scheduling rules.
module tb_uart_tx_sched;

    localparam int N        = 4;
    localparam int D        = 8;
    localparam int IW       = 2;
    localparam int START_TO = 4;
    localparam int FRAME    = 11;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*D-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic [N-1:0]   req_ready;
    logic           tx_ena;
    logic [D-1:0]   tx_data;
    logic           tx_busy = 1'b0;
    logic [IW-1:0]  grant_id;
    logic           locked;
    logic           err_start;

    uart_tx_sched #(
        .N_REQ    (N),
        .D_WIDTH  (D),
        .START_TO (START_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_ena    (tx_ena),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .locked    (locked),
        .err_start (err_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } item_t;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] d;
    } acc_t;

    item_t src_q[N][$];
    acc_t  acc_log[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    bit         rst_cmd    = 1'b0;
    bit [N-1:0] en         = '1;
    bit         force_busy = 1'b0;
    bit         dead       = 1'b0;
    int         dead_pct   = 0;
    int         busy_left  = 0;
    int         busy_cycles = 0;

    // Model of the scheduler: free/busy plus message ownership and rotation.
    bit         m_idle   = 1'b1;
    int         m_launch = -1;
    int         m_watch  = 0;
    bit         m_seen   = 1'b0;
    int         m_zeros  = 0;
    bit         m_lock   = 1'b0;
    int         m_gid    = 0;
    int         m_ptr    = 0;
    bit         m_err    = 1'b0;
    logic [7:0] m_data   = '0;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idle   = 1'b1;
        m_launch = -1;
        m_seen   = 1'b0;
        m_zeros  = 0;
        m_lock   = 1'b0;
        m_gid    = 0;
        m_ptr    = 0;
        m_err    = 1'b0;
        m_data   = '0;
    endtask

    task automatic apply_stimulus();
        @(negedge clk);
        cyc++;
        rst = rst_cmd;
        if (busy_left > 0) begin
            tx_busy = 1'b1;
            busy_left--;
        end else begin
            tx_busy = force_busy;
        end
        if (tx_busy) busy_cycles++;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]         = en[i];
                req_data[i*D +: D]   = src_q[i][0].d;
                req_last[i]          = src_q[i][0].last;
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*D +: D]   = '0;
                req_last[i]          = 1'b0;
            end
        end
        if (!rst) model_reset();
    endtask

    // Which requester the rules say gets the byte this cycle, or -1.
    function automatic int pick_winner();
        int idx;
        if (!rst || !m_idle || tx_busy) return -1;
        if (m_lock) begin
            idx = m_gid;
            return req_valid[idx[IW-1:0]] ? m_gid : -1;
        end
        for (int off = 0; off < N; off++) begin
            idx = (m_ptr + off) % N;
            if (req_valid[idx[IW-1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input int w);
        item_t it;
        if (!rst) return;
        if (m_idle) begin
            if (w >= 0) begin
                it       = src_q[w].pop_front();
                m_data   = it.d;
                m_gid    = w;
                m_lock   = !it.last;
                if (it.last) m_ptr = (w + 1) % N;
                m_idle   = 1'b0;
                m_launch = cyc + 1;
                m_watch  = cyc + 2;
                m_seen   = 1'b0;
                m_zeros  = 0;
                acc_log.push_back('{cyc, w, it.d});
            end
        end else if (cyc >= m_watch) begin
            if (m_seen) begin
                if (!tx_busy) m_idle = 1'b1;
            end else if (tx_busy) begin
                m_seen = 1'b1;
            end else begin
                m_zeros++;
                if (m_zeros == START_TO) begin
                    m_err  = 1'b1;
                    m_lock = 1'b0;
                    m_ptr  = (m_gid + 1) % N;
                    m_idle = 1'b1;
                end
            end
        end
    endtask

    task automatic check_output();
        int         w;
        logic [N-1:0] exp_ready;
        w = pick_winner();
        exp_ready = (w >= 0) ? (N'(1) << w) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("tx_ena",    32'(tx_ena),    32'(cyc == m_launch));
        check("tx_data",   32'(tx_data),   32'(m_data));
        check("grant_id",  32'(grant_id),  32'(m_gid));
        check("locked",    32'(locked),    32'(m_lock));
        check("err_start", 32'(err_start), 32'(m_err));
        model_step(w);
        // Transmitter responder: busy for FRAME cycles starting the cycle after the launch.
        if (rst && tx_ena === 1'b1 && !dead && ($urandom_range(99) >= dead_pct))
            busy_left = FRAME;
    endtask

    task automatic step();
        apply_stimulus();
        #1;
        check_output();
    endtask

    task automatic run_until_log(input int target, input int budget, input string name);
        int k = 0;
        while (acc_log.size() < target && k < budget) begin
            step();
            k++;
        end
        vectors++;
        if (acc_log.size() < target) begin
            miscompares++;
            $display("[TB] FAIL %s accepts=%0d required=%0d within %0d cycles",
                     name, acc_log.size(), target, budget);
        end
    endtask

    task automatic do_reset();
        rst_cmd = 1'b0;
        repeat (2) step();
        rst_cmd = 1'b1;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic last);
        src_q[i].push_back('{d: d, last: last});
    endtask

    initial begin
        int base;
        int mark;
        int drain;

        $display("[TB] start");
        rst_cmd = 1'b0;
        repeat (3) step();
        rst_cmd = 1'b1;
        step();

        // Single byte from requester 0.
        busy_cycles = 0;
        base = acc_log.size();
        push(0, 8'hA5, 1'b1);
        run_until_log(base + 1, 50, "single_accept");
        repeat (16) step();
        if (acc_log.size() > base) begin
            check("single_id",   32'(acc_log[base].id), 32'd0);
            check("single_data", 32'(acc_log[base].d),  32'hA5);
        end
        check("single_busy_len", 32'(busy_cycles), 32'd11);
        check("single_txdata",   32'(tx_data),     32'hA5);
        check("single_locked",   32'(locked),      32'd0);

        // Fairness from pointer 0, all single-byte messages.
        do_reset();
        base = acc_log.size();
        push(0, 8'hC0, 1'b1);
        push(0, 8'hC4, 1'b1);
        push(1, 8'hC1, 1'b1);
        push(2, 8'hC2, 1'b1);
        push(3, 8'hC3, 1'b1);
        run_until_log(base + 5, 200, "fair_accepts");
        repeat (16) step();
        if (acc_log.size() >= base + 5) begin
            for (int i = 0; i < 5; i++)
                check("fair_order", 32'(acc_log[base+i].id), 32'(i % 4));
            for (int i = 0; i < 4; i++)
                check("fair_spacing", 32'(acc_log[base+i+1].cyc - acc_log[base+i].cyc), 32'(FRAME + 3));
        end

        // Locked three-byte message while requester 1 waits.
        do_reset();
        base = acc_log.size();
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        push(1, 8'h44, 1'b1);
        run_until_log(base + 4, 200, "lock_accepts");
        repeat (16) step();
        if (acc_log.size() >= base + 4) begin
            check("lock_id0", 32'(acc_log[base].id),   32'd0);
            check("lock_id2", 32'(acc_log[base+2].id), 32'd0);
            check("lock_id3", 32'(acc_log[base+3].id), 32'd1);
            check("lock_d1",  32'(acc_log[base+1].d),  32'h22);
            check("lock_d3",  32'(acc_log[base+3].d),  32'h44);
        end

        // Start timeout: transmitter never raises busy.
        dead = 1'b1;
        base = acc_log.size();
        push(2, 8'h55, 1'b0);
        push(3, 8'h66, 1'b1);
        run_until_log(base + 2, 100, "timeout_accepts");
        repeat (8) step();
        if (acc_log.size() >= base + 2) begin
            check("to_id_first",  32'(acc_log[base].id),   32'd2);
            check("to_id_next",   32'(acc_log[base+1].id), 32'd3);
            check("to_spacing",   32'(acc_log[base+1].cyc - acc_log[base].cyc), 32'(START_TO + 2));
        end
        check("to_err_sticky", 32'(err_start), 32'd1);
        dead = 1'b0;

        // Reset during WAIT_DONE with 5 busy cycles still to come.
        base = acc_log.size();
        push(1, 8'h77, 1'b1);
        run_until_log(base + 1, 50, "midreset_accept");
        drain = 0;
        while (!(busy_left == 5 && tx_busy) && drain < 30) begin
            step();
            drain++;
        end
        check("midreset_reach", 32'(busy_left), 32'd5);
        mark = cyc;
        rst_cmd = 1'b0;
        push(3, 8'h99, 1'b1);
        repeat (2) step();
        check("midreset_err_clr", 32'(err_start), 32'd0);
        rst_cmd = 1'b1;
        run_until_log(base + 2, 50, "midreset_after");
        if (acc_log.size() >= base + 2) begin
            check("midreset_id",   32'(acc_log[base+1].id), 32'd3);
            check("midreset_wait", 32'(acc_log[base+1].cyc - mark), 32'd6);
        end
        repeat (16) step();

        // Busy while idle blocks the accept until it drops.
        force_busy = 1'b1;
        base = acc_log.size();
        push(1, 8'hAB, 1'b1);
        repeat (6) step();
        check("busyidle_ready", 32'(req_ready), 32'd0);
        check("busyidle_none",  32'(acc_log.size()), 32'(base));
        force_busy = 1'b0;
        run_until_log(base + 1, 10, "busyidle_accept");
        if (acc_log.size() > base)
            check("busyidle_id", 32'(acc_log[base].id), 32'd1);
        repeat (16) step();

        // Random traffic with occasional silent transmitter launches.
        dead_pct = 10;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() < 2 && $urandom_range(7) == 0) begin
                    int len;
                    len = $urandom_range(3, 1);
                    for (int b = 0; b < len; b++)
                        push(i, 8'($urandom_range(255)), b == len - 1);
                end
                en[i] = ($urandom_range(3) != 0);
            end
            step();
        end
        en = '1;
        dead_pct = 0;
        drain = 0;
        while (drain < 2000 && !(m_idle && busy_left == 0 &&
               src_q[0].size() == 0 && src_q[1].size() == 0 &&
               src_q[2].size() == 0 && src_q[3].size() == 0)) begin
            step();
            drain++;
        end
        check("drain_done", 32'(drain < 2000), 32'd1);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
